// File: rtl/mem_req_arbiter.sv
// Two-client arbiter for the shared Memory150 DDR2 channel: icache refill and dcache refill/writeback.
// One line transaction in flight; round-robin on contention; read beats steered to the owner.
module mem_req_arbiter #(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 128,
  parameter int BEATS  = 2,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_rdata_valid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rdata_last,

  input  logic              dc_req_valid,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_rnw,
  output logic              dc_req_ready,
  input  logic              dc_wdata_valid,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic [MASK_W-1:0] dc_wdata_mask,
  output logic              dc_wdata_ready,
  output logic              dc_rdata_valid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rdata_last,

  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_cmd_rnw,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wdata_mask,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t             state;
  logic               owner_dc;
  logic               last_grant_dc;
  logic               rnw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   beat_cnt;

  logic idle_act;
  logic grant_dc;
  logic grant_ic;
  logic wdata_act;
  logic wbeat;
  logic rbeat;
  logic last_beat;

  // NOTE: reset is synchronous, so every valid/ready is also masked by rst
  // combinationally to hold them low during the reset cycle itself.
  assign idle_act  = (state == IDLE)  && !rst;
  assign wdata_act = (state == WDATA) && !rst;
  assign rbeat     = (state == RDATA) && !rst && mem_rdata_valid;
  assign wbeat     = wdata_act && dc_wdata_valid && mem_wdata_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // On a tie the dcache wins unless it was the most recent grant.
  assign grant_dc = idle_act && dc_req_valid && (!ic_req_valid || !last_grant_dc);
  assign grant_ic = idle_act && ic_req_valid && !grant_dc;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner_dc      <= 1'b0;
      last_grant_dc <= 1'b0;
      rnw_q         <= 1'b0;
      addr_q        <= '0;
      beat_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dc || grant_ic) begin
            owner_dc      <= grant_dc;
            last_grant_dc <= grant_dc;
            addr_q        <= grant_dc ? dc_req_addr : ic_req_addr;
            rnw_q         <= grant_dc ? dc_req_rnw : 1'b1;
            state         <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            beat_cnt <= '0;
            state    <= rnw_q ? RDATA : WDATA;
          end
        end
        WDATA: begin
          if (wbeat) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RDATA: begin
          if (rbeat) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ic_req_ready    = grant_ic;
  assign dc_req_ready    = grant_dc;

  assign mem_cmd_valid   = (state == CMD) && !rst;
  assign mem_cmd_addr    = rst ? '0 : addr_q;
  assign mem_cmd_rnw     = rst ? 1'b0 : rnw_q;

  // Write beats pass straight through; the arbiter only counts handshakes.
  assign mem_wdata_valid = wdata_act && dc_wdata_valid;
  assign dc_wdata_ready  = wdata_act && mem_wdata_ready;
  assign mem_wdata       = rst ? '0 : dc_wdata;
  assign mem_wdata_mask  = rst ? '0 : dc_wdata_mask;

  assign ic_rdata_valid  = rbeat && !owner_dc;
  assign dc_rdata_valid  = rbeat &&  owner_dc;
  assign ic_rdata_last   = ic_rdata_valid && last_beat;
  assign dc_rdata_last   = dc_rdata_valid && last_beat;
  assign ic_rdata        = rst ? '0 : mem_rdata;
  assign dc_rdata        = rst ? '0 : mem_rdata;

endmodule
